// File: rtl/switch_nport_if.sv
// Handshake bundle for switch_nport. Port i occupies slice i of every
// flattened vector.
interface switch_nport_if #(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned DATA_W  = 8
);
  logic [N_PORTS-1:0]        in_valid;
  logic [N_PORTS-1:0]        in_ready;
  logic [N_PORTS-1:0]        in_sop;
  logic [N_PORTS-1:0]        in_eop;
  logic [N_PORTS*DATA_W-1:0] in_data;
  logic [N_PORTS-1:0]        out_valid;
  logic [N_PORTS-1:0]        out_ready;
  logic [N_PORTS-1:0]        out_sop;
  logic [N_PORTS-1:0]        out_eop;
  logic [N_PORTS*DATA_W-1:0] out_data;
  logic [15:0]               drop_count;

  modport master (
    output in_valid, in_sop, in_eop, in_data, out_ready,
    input  in_ready, out_valid, out_sop, out_eop, out_data, drop_count
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_data, out_ready,
    output in_ready, out_valid, out_sop, out_eop, out_data, drop_count
  );
endinterface

// File: rtl/switch_nport.sv
// N-port packet switch: a private FIFO per ingress, and a round-robin
// arbiter per egress that locks onto one ingress for a whole packet.
module switch_nport #(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PORT_W  = (N_PORTS > 2) ? $clog2(N_PORTS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  switch_nport_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = DATA_W + 2;

  typedef enum logic [1:0] {IN_IDLE = 2'd0, IN_ROUTED = 2'd1, IN_DROP = 2'd2} in_state_e;
  typedef enum logic {EG_IDLE = 1'b0, EG_BUSY = 1'b1} eg_state_e;

  logic [AW-1:0]     r_wptr     [N_PORTS];
  logic [AW-1:0]     r_rptr     [N_PORTS];
  logic [CW-1:0]     r_count    [N_PORTS];
  in_state_e         r_in_state [N_PORTS];
  eg_state_e         r_eg_state [N_PORTS];
  logic [PORT_W-1:0] r_eg_sel   [N_PORTS];
  logic [PORT_W-1:0] r_rr_ptr   [N_PORTS];
  logic [15:0]       r_drop_count;

  logic [N_PORTS-1:0]        w_empty, w_in_ready, w_wr, w_pop, w_req, w_bad_dest;
  logic [N_PORTS-1:0]        w_granted, w_gnt_vld, w_eg_pop;
  logic [N_PORTS-1:0]        w_head_sop, w_head_eop;
  logic [DATA_W-1:0]         w_head_data [N_PORTS];
  logic [PORT_W-1:0]         w_dest      [N_PORTS];
  logic [PORT_W-1:0]         w_gnt_idx   [N_PORTS];
  logic [N_PORTS-1:0]        w_out_valid, w_out_sop, w_out_eop;
  logic [N_PORTS*DATA_W-1:0] w_out_data;
  logic [4:0]                w_drop_inc;
  logic [16:0]               w_drop_sum;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_in
    logic [EW-1:0] r_mem [DEPTH];
    logic [EW-1:0] w_head;

    assign w_head          = r_mem[r_rptr[gi]];
    assign w_head_sop[gi]  = w_head[EW-1];
    assign w_head_eop[gi]  = w_head[EW-2];
    assign w_head_data[gi] = w_head[DATA_W-1:0];
    assign w_dest[gi]      = w_head[PORT_W-1:0];
    assign w_empty[gi]     = (r_count[gi] == '0);
    assign w_in_ready[gi]  = (r_count[gi] != CW'(DEPTH));
    assign w_wr[gi]        = bus.in_valid[gi] && w_in_ready[gi];
    assign w_bad_dest[gi]  = (32'(w_dest[gi]) >= N_PORTS);
    // Only an idle ingress requests, so each ingress holds at most one grant.
    assign w_req[gi]       = (r_in_state[gi] == IN_IDLE) && !w_empty[gi] && !w_bad_dest[gi];

    always_ff @(posedge clk) begin
      if (w_wr[gi]) begin
        r_mem[r_wptr[gi]] <= {bus.in_sop[gi], bus.in_eop[gi], bus.in_data[gi*DATA_W +: DATA_W]};
      end
    end
  end

  always_comb begin
    int unsigned idx;
    idx       = 0;
    w_gnt_vld = '0;
    w_granted = '0;
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      w_gnt_idx[j] = '0;
      for (int unsigned k = 1; k <= N_PORTS; k++) begin
        idx = 32'(r_rr_ptr[j]) + k;
        if (idx >= N_PORTS) idx = idx - N_PORTS;
        if (!w_gnt_vld[j] && (r_eg_state[j] == EG_IDLE) && w_req[idx] &&
            (32'(w_dest[idx]) == j)) begin
          w_gnt_vld[j] = 1'b1;
          w_gnt_idx[j] = PORT_W'(idx);
        end
      end
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        if (w_gnt_vld[j] && (32'(w_gnt_idx[j]) == i)) w_granted[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_out_valid = '0;
    w_out_sop   = '0;
    w_out_eop   = '0;
    w_out_data  = '0;
    w_eg_pop    = '0;
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      if (r_eg_state[j] == EG_BUSY) begin
        w_out_valid[j]                 = !w_empty[r_eg_sel[j]];
        w_out_sop[j]                   = w_head_sop[r_eg_sel[j]];
        w_out_eop[j]                   = w_head_eop[r_eg_sel[j]];
        w_out_data[j*DATA_W +: DATA_W] = w_head_data[r_eg_sel[j]];
      end
      w_eg_pop[j] = w_out_valid[j] && bus.out_ready[j];
    end
  end

  always_comb begin
    w_pop      = '0;
    w_drop_inc = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if ((r_in_state[i] == IN_DROP) && !w_empty[i]) begin
        w_pop[i] = 1'b1;
        if (w_head_eop[i]) w_drop_inc = w_drop_inc + 5'd1;
      end
      for (int unsigned j = 0; j < N_PORTS; j++) begin
        if (w_eg_pop[j] && (32'(r_eg_sel[j]) == i)) w_pop[i] = 1'b1;
      end
    end
    w_drop_sum = {1'b0, r_drop_count} + 17'(w_drop_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        r_wptr[i]     <= '0;
        r_rptr[i]     <= '0;
        r_count[i]    <= '0;
        r_in_state[i] <= IN_IDLE;
      end
    end else begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        if (w_wr[i])  r_wptr[i] <= r_wptr[i] + AW'(1);
        if (w_pop[i]) r_rptr[i] <= r_rptr[i] + AW'(1);
        r_count[i] <= r_count[i] + CW'(w_wr[i]) - CW'(w_pop[i]);
        case (r_in_state[i])
          IN_IDLE: begin
            if (w_granted[i])                     r_in_state[i] <= IN_ROUTED;
            else if (!w_empty[i] && w_bad_dest[i]) r_in_state[i] <= IN_DROP;
          end
          IN_ROUTED, IN_DROP: begin
            if (w_pop[i] && w_head_eop[i]) r_in_state[i] <= IN_IDLE;
          end
          default: r_in_state[i] <= IN_IDLE;
        endcase
      end
    end
  end

  // Reset pointer N_PORTS-1 makes port 0 the first winner on every egress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < N_PORTS; j++) begin
        r_eg_state[j] <= EG_IDLE;
        r_eg_sel[j]   <= '0;
        r_rr_ptr[j]   <= PORT_W'(N_PORTS - 1);
      end
      r_drop_count <= '0;
    end else begin
      for (int unsigned j = 0; j < N_PORTS; j++) begin
        case (r_eg_state[j])
          EG_IDLE: begin
            if (w_gnt_vld[j]) begin
              r_eg_state[j] <= EG_BUSY;
              r_eg_sel[j]   <= w_gnt_idx[j];
              r_rr_ptr[j]   <= w_gnt_idx[j];
            end
          end
          EG_BUSY: begin
            if (w_eg_pop[j] && w_out_eop[j]) r_eg_state[j] <= EG_IDLE;
          end
          default: r_eg_state[j] <= EG_IDLE;
        endcase
      end
      r_drop_count <= w_drop_sum[16] ? '1 : w_drop_sum[15:0];
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_sop    = w_out_sop;
  assign bus.out_eop    = w_out_eop;
  assign bus.out_data   = w_out_data;
  assign bus.drop_count = r_drop_count;
endmodule

// File: tb/tb_switch_nport.sv
// Scoreboard bench for switch_nport: a 4-port/DEPTH 16 instance and a
// 3-port/DEPTH 4 instance share one clock.
module tb_switch_nport;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [9:0] exp_a [4][$];
  logic [9:0] exp_b [3][$];
  int         obs_a [4][$];
  int         obs_b [3][$];

  switch_nport_if #(.N_PORTS(4), .DATA_W(8)) ifa ();
  switch_nport_if #(.N_PORTS(3), .DATA_W(8)) ifb ();

  switch_nport #(.N_PORTS(4), .DATA_W(8), .DEPTH(16)) dut_a (.clk(clk), .rst_n(rst_a), .bus(ifa));
  switch_nport #(.N_PORTS(3), .DATA_W(8), .DEPTH(4))  dut_b (.clk(clk), .rst_n(rst_b), .bus(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    logic [9:0] got, e;
    for (int j = 0; j < 4; j++) begin
      if (ifa.out_valid[j] && ifa.out_ready[j]) begin
        got = {ifa.out_sop[j], ifa.out_eop[j], ifa.out_data[j*8 +: 8]};
        obs_a[j].push_back(cyc);
        n_tests++;
        if (exp_a[j].size() == 0) begin
          n_fail++;
          $display("FAIL a_egress%0d_word got=%h expected=none", j, got);
        end else begin
          e = exp_a[j].pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL a_egress%0d_word got=%h expected=%h", j, got, e);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [9:0] got, e;
    for (int j = 0; j < 3; j++) begin
      if (ifb.out_valid[j] && ifb.out_ready[j]) begin
        got = {ifb.out_sop[j], ifb.out_eop[j], ifb.out_data[j*8 +: 8]};
        obs_b[j].push_back(cyc);
        n_tests++;
        if (exp_b[j].size() == 0) begin
          n_fail++;
          $display("FAIL b_egress%0d_word got=%h expected=none", j, got);
        end else begin
          e = exp_b[j].pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL b_egress%0d_word got=%h expected=%h", j, got, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic set_in(input int d, input int p, input logic v, input logic s,
                        input logic e, input logic [7:0] dat);
    if (d == 0) begin
      ifa.in_valid[p] = v; ifa.in_sop[p] = s; ifa.in_eop[p] = e; ifa.in_data[p*8 +: 8] = dat;
    end else begin
      ifb.in_valid[p] = v; ifb.in_sop[p] = s; ifb.in_eop[p] = e; ifb.in_data[p*8 +: 8] = dat;
    end
  endtask

  task automatic push_pkt(input int d, input int j, input logic [7:0] hdr,
                          input int len, input logic [7:0] base);
    logic [7:0] dat;
    for (int w = 0; w < len; w++) begin
      dat = (w == 0) ? hdr : base + 8'(w);
      if (d == 0) exp_a[j].push_back({w == 0, w == len - 1, dat});
      else        exp_b[j].push_back({w == 0, w == len - 1, dat});
    end
  endtask

  // Called at posedge+1; k0 is the edge count at which the header was accepted.
  task automatic send(input int d, input int p, input logic [7:0] hdr, input int len,
                      input logic [7:0] base, output int k0);
    logic rdy;
    int   guard;
    k0 = -1;
    for (int w = 0; w < len; w++) begin
      set_in(d, p, 1'b1, w == 0, w == len - 1, (w == 0) ? hdr : base + 8'(w));
      guard = 0;
      do begin
        rdy = (d == 0) ? ifa.in_ready[p] : ifb.in_ready[p];
        @(posedge clk); #1;
        guard++;
      end while (!rdy && guard < 200);
      if (!rdy) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout dut=%0d port=%0d word=%0d got=stalled expected=accepted", d, p, w);
        break;
      end
      if (w == 0) k0 = cyc;
    end
    set_in(d, p, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_obs();
    for (int j = 0; j < 4; j++) obs_a[j].delete();
    for (int j = 0; j < 3; j++) obs_b[j].delete();
  endtask

  task automatic chk_obs(input string name, input int d, input int j, input int first,
                         input int n, input int start);
    int got;
    for (int w = 0; w < n; w++) begin
      if (d == 0) got = (first + w < obs_a[j].size()) ? obs_a[j][first + w] : -1;
      else        got = (first + w < obs_b[j].size()) ? obs_b[j][first + w] : -1;
      chk(name, got, start + w);
    end
  endtask

  initial begin
    int k0, k1, k2, k3;
    ifa.in_valid = '0; ifa.in_sop = '0; ifa.in_eop = '0; ifa.in_data = '0; ifa.out_ready = '1;
    ifb.in_valid = '0; ifb.in_sop = '0; ifb.in_eop = '0; ifb.in_data = '0; ifb.out_ready = '1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_out_valid", 32'(ifa.out_valid), 32'h0);
    chk("rst_a_in_ready", 32'(ifa.in_ready), 32'hF);
    chk("rst_a_out_data", 32'(ifa.out_data), 32'h0);
    chk("rst_b_in_ready", 32'(ifb.in_ready), 32'h7);
    chk("rst_b_drop_count", 32'(ifb.drop_count), 32'h0);
    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_a_out_valid", 32'(ifa.out_valid), 32'h0);
    chk("post_rst_a_in_ready", 32'(ifa.in_ready), 32'hF);

    // Single packet 0 -> 2
    clear_obs();
    push_pkt(0, 2, 8'h02, 4, 8'h10);
    send(0, 0, 8'h02, 4, 8'h10, k0);
    repeat (8) @(posedge clk); #1;
    chk("t1_count", obs_a[2].size(), 4);
    chk_obs("t1_cycle", 0, 2, 0, 4, k0 + 1);

    // Contention on egress 0: port 1 wins from reset pointer, one idle cycle, then port 3
    clear_obs();
    push_pkt(0, 0, 8'h40, 3, 8'h40);
    push_pkt(0, 0, 8'h80, 3, 8'h80);
    fork
      send(0, 1, 8'h40, 3, 8'h40, k1);
      send(0, 3, 8'h80, 3, 8'h80, k3);
    join
    repeat (10) @(posedge clk); #1;
    chk("t2_count", obs_a[0].size(), 6);
    chk_obs("t2_first_cycle", 0, 0, 0, 3, k1 + 1);
    chk_obs("t2_second_cycle", 0, 0, 3, 3, k1 + 5);

    // Port 1 alone moves the pointer to 1, so port 3 wins the next contention
    push_pkt(0, 0, 8'h44, 2, 8'h44);
    send(0, 1, 8'h44, 2, 8'h44, k1);
    repeat (6) @(posedge clk); #1;
    clear_obs();
    push_pkt(0, 0, 8'h88, 3, 8'h88);
    push_pkt(0, 0, 8'h48, 3, 8'h48);
    fork
      send(0, 1, 8'h48, 3, 8'h48, k1);
      send(0, 3, 8'h88, 3, 8'h88, k3);
    join
    repeat (10) @(posedge clk); #1;
    chk("t2r_count", obs_a[0].size(), 6);
    chk_obs("t2r_first_cycle", 0, 0, 0, 3, k3 + 1);
    chk_obs("t2r_second_cycle", 0, 0, 3, 3, k3 + 5);

    // Parallel: port i -> egress (i+1)%4
    clear_obs();
    push_pkt(0, 1, 8'h11, 4, 8'h11);
    push_pkt(0, 2, 8'h22, 4, 8'h22);
    push_pkt(0, 3, 8'h33, 4, 8'h33);
    push_pkt(0, 0, 8'h40, 4, 8'h50);
    fork
      send(0, 0, 8'h11, 4, 8'h11, k0);
      send(0, 1, 8'h22, 4, 8'h22, k1);
      send(0, 2, 8'h33, 4, 8'h33, k2);
      send(0, 3, 8'h40, 4, 8'h50, k3);
    join
    repeat (8) @(posedge clk); #1;
    chk_obs("t3_eg1_cycle", 0, 1, 0, 4, k0 + 1);
    chk_obs("t3_eg2_cycle", 0, 2, 0, 4, k0 + 1);
    chk_obs("t3_eg3_cycle", 0, 3, 0, 4, k0 + 1);
    chk_obs("t3_eg0_cycle", 0, 0, 0, 4, k0 + 1);

    // Reset during word 2 of a 5-word packet 2 -> 1 held at egress
    clear_obs();
    ifa.out_ready[1] = 1'b0;
    set_in(0, 2, 1'b1, 1'b1, 1'b0, 8'h21);
    @(posedge clk); #1;
    set_in(0, 2, 1'b1, 1'b0, 1'b0, 8'h22);
    @(posedge clk); #1;
    set_in(0, 2, 1'b1, 1'b0, 1'b0, 8'h23);
    #2;
    chk("t4_pre_valid", 32'(ifa.out_valid[1]), 32'h1);
    rst_a = 1'b0;
    #1;
    chk("t4_rst_out_valid", 32'(ifa.out_valid), 32'h0);
    chk("t4_rst_in_ready", 32'(ifa.in_ready), 32'hF);
    chk("t4_rst_drop_count", 32'(ifa.drop_count), 32'h0);
    chk("t4_rst_out_data", 32'(ifa.out_data), 32'h0);
    set_in(0, 2, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #3;
    rst_a = 1'b1;
    @(posedge clk); #1;
    ifa.out_ready[1] = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("t4_no_stale_words", obs_a[1].size(), 0);
    push_pkt(0, 1, 8'h61, 3, 8'h61);
    send(0, 2, 8'h61, 3, 8'h61, k0);
    repeat (6) @(posedge clk); #1;
    chk("t4_fresh_count", obs_a[1].size(), 3);
    chk_obs("t4_fresh_cycle", 0, 1, 0, 3, k0 + 1);

    // Backpressure on the 3-port, DEPTH 4 instance
    clear_obs();
    ifb.out_ready = '0;
    push_pkt(1, 1, 8'h05, 6, 8'h05);
    fork
      send(1, 0, 8'h05, 6, 8'h05, k0);
      begin
        repeat (8) @(posedge clk); #1;
        chk("t5_in_ready_full", 32'(ifb.in_ready[0]), 32'h0);
        chk("t5_out_valid_held", 32'(ifb.out_valid[1]), 32'h1);
        chk("t5_nothing_out", obs_b[1].size(), 0);
        ifb.out_ready = '1;
      end
    join
    repeat (10) @(posedge clk); #1;
    chk("t5_count", obs_b[1].size(), 6);
    chk("t5_in_ready_after", 32'(ifb.in_ready[0]), 32'h1);

    // Destination 3 does not exist on the 3-port instance
    clear_obs();
    send(1, 2, 8'h03, 5, 8'h30, k0);
    @(posedge clk); #1;
    chk("t6_drop_before_eop", 32'(ifb.drop_count), 32'h0);
    @(posedge clk); #1;
    chk("t6_drop_after_eop", 32'(ifb.drop_count), 32'h1);
    repeat (3) @(posedge clk); #1;
    chk("t6_no_output", obs_b[0].size() + obs_b[1].size() + obs_b[2].size(), 0);
    push_pkt(1, 0, 8'h20, 3, 8'h20);
    send(1, 2, 8'h20, 3, 8'h20, k0);
    repeat (6) @(posedge clk); #1;
    chk("t6_next_count", obs_b[0].size(), 3);
    chk_obs("t6_next_cycle", 1, 0, 0, 3, k0 + 1);
    chk("t6_drop_stable", 32'(ifb.drop_count), 32'h1);

    repeat (5) @(posedge clk); #1;
    for (int j = 0; j < 4; j++) chk("drain_a", exp_a[j].size(), 0);
    for (int j = 0; j < 3; j++) chk("drain_b", exp_b[j].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
